debug_uart_arbiter: RTL and testbench

- Sequences the single debug UART transmitter and shares it between two byte sources: CPU writes to the DEBUG_UART address, and a hardware trace source.
- CPU bytes are buffered in a small FIFO, so firmware does not stall on every character.
- Round-robin arbitration selects the next source and issues exactly one transmit request per byte.
- The block completes that request against the transmitter's busy handshake before the next arbitration.

---
 rtl/debug_uart_arbiter_if.sv | 61 ++++++
 rtl/debug_uart_arbiter.sv | 178 +++++++++++++++++
 tb/tb_debug_uart_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_uart_arbiter_if.sv
// ----------------------------------------------------------------------------
// debug_uart_arbiter_if
// Groups the signals of the debug UART arbiter, which are all
// single-clock-domain signals:
//   - the CPU write port and the FIFO status outputs,
//   - the trace valid/ready handshake,
//   - the transmitter start/busy handshake,
//   - the activity and last-source status outputs.
// Modports:
//   master : environment side. Drives CPU writes, trace bytes and the
//            transmitter busy input.
//   slave  : arbiter side. Drives the status outputs, trc_ready and the
//            transmit request.
// Parameter:
//   LEVEL_W : width of cpu_fifo_level.
// ----------------------------------------------------------------------------
interface debug_uart_arbiter_if #(
    parameter int LEVEL_W = 3
);
    // CPU byte port and FIFO status
    logic               cpu_wr_en;
    logic [7:0]         cpu_wr_data;
    logic               cpu_fifo_full;
    logic [LEVEL_W-1:0] cpu_fifo_level;
    logic               cpu_ovf;
    logic               cpu_ovf_clr;

    // Trace source handshake
    logic               trc_valid;
    logic [7:0]         trc_data;
    logic               trc_ready;

    // Transmitter handshake
    logic               uart_tx_en;
    logic [7:0]         uart_tx_data;
    logic               uart_tx_busy;

    // Status
    logic               tx_active;
    logic               last_src;

    modport master (
        output cpu_wr_en, cpu_wr_data, cpu_ovf_clr,
        output trc_valid, trc_data,
        output uart_tx_busy,
        input  cpu_fifo_full, cpu_fifo_level, cpu_ovf,
        input  trc_ready,
        input  uart_tx_en, uart_tx_data,
        input  tx_active, last_src
    );

    modport slave (
        input  cpu_wr_en, cpu_wr_data, cpu_ovf_clr,
        input  trc_valid, trc_data,
        input  uart_tx_busy,
        output cpu_fifo_full, cpu_fifo_level, cpu_ovf,
        output trc_ready,
        output uart_tx_en, uart_tx_data,
        output tx_active, last_src
    );
endinterface

// File: rtl/debug_uart_arbiter.sv
// ----------------------------------------------------------------------------
// debug_uart_arbiter
// Shares the single debug UART transmitter between two byte sources:
//   - CPU writes, which are buffered in a small FIFO,
//   - a hardware trace source that uses a valid/ready handshake.
// A round-robin arbiter picks one byte while the block is IDLE. The block
// then issues one start pulse for that byte and follows the transmitter's
// busy handshake until the transfer ends. Only then does it arbitrate again.
// Ports:
//   clk : clock, single domain.
//   rst : synchronous reset, active-high.
//   bus : debug_uart_arbiter_if.slave. Carries the CPU FIFO port, the trace
//         handshake, the transmitter handshake and the status outputs.
// Parameters:
//   FIFO_DEPTH : CPU FIFO depth. Must be a power of two, at least 2.
//   LEVEL_W    : width of cpu_fifo_level. Equals log2(FIFO_DEPTH)+1.
//   BUSY_WAIT  : number of cycles to wait for busy to rise before the start
//                is treated as lost.
// ----------------------------------------------------------------------------
module debug_uart_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int LEVEL_W    = 3,
    parameter int BUSY_WAIT  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    debug_uart_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(BUSY_WAIT + 1);
    localparam logic [LEVEL_W-1:0] DEPTH_L   = LEVEL_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]   WAIT_LAST = CNT_W'(BUSY_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LEVEL_W-1:0] r_level;
    logic               r_ovf;
    logic               r_last_src;
    logic [7:0]         r_tx_data;
    logic [CNT_W-1:0]   r_wait_cnt;

    logic               w_push;
    logic               w_drop;
    logic               w_cpu_req;
    logic               w_trc_req;
    logic               w_grant_cpu;
    logic               w_grant_trc;
    logic               w_cnt_clr;
    logic               w_cnt_inc;

    // Push acceptance uses the registered level only. This means a push at
    // full is dropped even when a pop happens in the same cycle.
    assign w_push    = bus.cpu_wr_en && (r_level != DEPTH_L);
    assign w_drop    = bus.cpu_wr_en && (r_level == DEPTH_L);
    assign w_cpu_req = (r_level != '0);
    assign w_trc_req = bus.trc_valid;

    // Next-state logic and arbitration
    always_comb begin
        w_state_next = r_state;
        w_grant_cpu  = 1'b0;
        w_grant_trc  = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        unique case (r_state)
            IDLE: begin
                // When both sources request, the one that did not win last
                // time is granted. If only one requests, it is granted.
                if (w_cpu_req && (!w_trc_req || r_last_src)) begin
                    w_grant_cpu = 1'b1;
                end else if (w_trc_req) begin
                    w_grant_trc = 1'b1;
                end
                if (w_grant_cpu || w_grant_trc) begin
                    w_state_next = START;
                end
            end
            START: begin
                w_cnt_clr    = 1'b1;
                w_state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.uart_tx_busy) begin
                    w_state_next = WAIT_DONE;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    // The start was lost. The byte is abandoned and is
                    // not queued again.
                    w_state_next = IDLE;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!bus.uart_tx_busy) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // FIFO storage has no reset, so it can map onto RAM. The head byte is
    // read into the registered transmit data when the CPU is granted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.cpu_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_ovf      <= 1'b0;
            r_last_src <= 1'b1;
            r_tx_data  <= 8'h00;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_state_next;

            // Pointers wrap naturally because the depth is a power of two.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_grant_cpu) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_grant_cpu) begin
                r_level <= r_level + 1'b1;
            end else if (!w_push && w_grant_cpu) begin
                r_level <= r_level - 1'b1;
            end

            // A set in the same cycle as a clear wins over the clear.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (bus.cpu_ovf_clr) begin
                r_ovf <= 1'b0;
            end

            if (w_grant_cpu) begin
                r_tx_data  <= r_mem[r_rd_ptr];
                r_last_src <= 1'b0;
            end else if (w_grant_trc) begin
                r_tx_data  <= bus.trc_data;
                r_last_src <= 1'b1;
            end

            if (w_cnt_clr) begin
                r_wait_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end
    end

    assign bus.cpu_fifo_full  = (r_level == DEPTH_L);
    assign bus.cpu_fifo_level = r_level;
    assign bus.cpu_ovf        = r_ovf;
    assign bus.trc_ready      = w_grant_trc;
    assign bus.uart_tx_en     = (r_state == START);
    assign bus.uart_tx_data   = r_tx_data;
    assign bus.tx_active      = (r_level != '0) || (r_state != IDLE);
    assign bus.last_src       = r_last_src;
endmodule

// File: tb/tb_debug_uart_arbiter.sv
// ----------------------------------------------------------------------------
// tb_debug_uart_arbiter
// Directed testbench for debug_uart_arbiter.
// - Each stimulus step pushes the bytes it expects to see transmitted, as
//   {src, data}, into a scoreboard queue.
// - A monitor process pops one entry for every uart_tx_en pulse and compares
//   it with the DUT outputs.
// - A simple transmitter model raises busy one cycle after each start pulse
//   and holds it for busy_len cycles. It can also be told never to raise busy.
// ----------------------------------------------------------------------------
module tb_debug_uart_arbiter;
    localparam int FIFO_DEPTH = 4;
    localparam int LEVEL_W    = 3;
    localparam int BUSY_WAIT  = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    debug_uart_arbiter_if #(.LEVEL_W(LEVEL_W)) bus ();

    debug_uart_arbiter #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .LEVEL_W    (LEVEL_W),
        .BUSY_WAIT  (BUSY_WAIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];
    int cyc = 0;
    int en_cnt = 0;
    int en_last = 0;
    int en_prev = 0;
    int trc_pulses = 0;
    int busy_len = 10;
    bit never_busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: samples one time unit after each rising edge.
    initial begin
        logic [8:0] e;
        forever begin
            @(posedge clk); #1;
            if (rst !== 1'b1) begin
                if (bus.trc_ready === 1'b1) trc_pulses++;
                if (bus.uart_tx_en === 1'b1) begin
                    en_prev = en_last;
                    en_last = cyc;
                    en_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_tx: got data %02h src %0d, expected no start pulse",
                                 bus.uart_tx_data, bus.last_src);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tx_data", {24'h0, bus.uart_tx_data}, {24'h0, e[7:0]});
                        chk("tx_src", {31'h0, bus.last_src}, {31'h0, e[8]});
                        $display("tx byte %02h src %0d at cycle %0d", bus.uart_tx_data, bus.last_src, cyc);
                    end
                end
            end
        end
    end

    // Transmitter model: raises busy one cycle after the start pulse.
    initial begin
        bus.uart_tx_busy = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bus.uart_tx_en === 1'b1 && !never_busy) begin
                @(negedge clk);
                @(negedge clk);
                bus.uart_tx_busy = 1'b1;
                repeat (busy_len) @(negedge clk);
                bus.uart_tx_busy = 1'b0;
            end
        end
    end

    // Drives a one-cycle push. Returns one time unit after the capturing edge.
    task automatic push(input logic [7:0] d);
        @(negedge clk);
        bus.cpu_wr_en   = 1'b1;
        bus.cpu_wr_data = d;
        @(posedge clk); #1;
        bus.cpu_wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max_cyc);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.tx_active !== 1'b0 || bus.uart_tx_busy !== 1'b0) && n < max_cyc) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_drain"}, (n < max_cyc) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Global watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        rst              = 1'b1;
        bus.cpu_wr_en    = 1'b0;
        bus.cpu_wr_data  = 8'h00;
        bus.cpu_ovf_clr  = 1'b0;
        bus.trc_valid    = 1'b0;
        bus.trc_data     = 8'h00;

        // Check the reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_level", {29'h0, bus.cpu_fifo_level}, 0);
        chk("rst_full", {31'h0, bus.cpu_fifo_full}, 0);
        chk("rst_ovf", {31'h0, bus.cpu_ovf}, 0);
        chk("rst_tx_en", {31'h0, bus.uart_tx_en}, 0);
        chk("rst_tx_data", {24'h0, bus.uart_tx_data}, 0);
        chk("rst_last_src", {31'h0, bus.last_src}, 1);
        chk("rst_tx_active", {31'h0, bus.tx_active}, 0);
        chk("rst_trc_ready", {31'h0, bus.trc_ready}, 0);
        @(negedge clk);
        rst = 1'b0;

        // T1: a single CPU byte, with busy held for 10 cycles.
        busy_len = 10;
        exp_q.push_back({1'b0, 8'h41});
        push(8'h41);
        chk("t1_level_after_push", {29'h0, bus.cpu_fifo_level}, 1);
        chk("t1_no_early_en", {31'h0, bus.uart_tx_en}, 0);
        @(posedge clk); #1;
        chk("t1_en_two_cycles_after_push", {31'h0, bus.uart_tx_en}, 1);
        chk("t1_level_popped", {29'h0, bus.cpu_fifo_level}, 0);
        n = 0;
        while (bus.uart_tx_busy !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
        chk("t1_busy_rose", {31'h0, bus.uart_tx_busy}, 1);
        chk("t1_active_while_busy", {31'h0, bus.tx_active}, 1);
        n = 0;
        while (bus.uart_tx_busy === 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        chk("t1_busy_fell", {31'h0, bus.uart_tx_busy}, 0);
        chk("t1_active_falls_with_busy", {31'h0, bus.tx_active}, 0);
        chk("t1_level_end", {29'h0, bus.cpu_fifo_level}, 0);

        // T2: CPU 01..04 and trace AA then BB. The sources alternate.
        do_reset();
        busy_len = 2;
        base = trc_pulses;
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b1, 8'hAA});
        exp_q.push_back({1'b0, 8'h02});
        exp_q.push_back({1'b1, 8'hBB});
        exp_q.push_back({1'b0, 8'h03});
        exp_q.push_back({1'b0, 8'h04});
        fork
            begin
                push(8'h01);
                push(8'h02);
                push(8'h03);
                push(8'h04);
            end
            begin
                int k;
                @(negedge clk);
                @(negedge clk);
                bus.trc_valid = 1'b1;
                bus.trc_data  = 8'hAA;
                k = 0;
                while (bus.trc_ready !== 1'b1 && k < 200) begin @(posedge clk); #1; k++; end
                chk("t2_aa_accepted", {31'h0, bus.trc_ready}, 1);
                @(negedge clk);
                @(negedge clk);
                bus.trc_data = 8'hBB;
                k = 0;
                while (bus.trc_ready !== 1'b1 && k < 200) begin @(posedge clk); #1; k++; end
                chk("t2_bb_accepted", {31'h0, bus.trc_ready}, 1);
                @(negedge clk);
                @(negedge clk);
                bus.trc_valid = 1'b0;
            end
        join
        wait_drain("t2", 300);
        chk("t2_trc_ready_pulses", trc_pulses - base, 2);

        // T3: fill the FIFO, then check overflow and its clear behaviour.
        busy_len = 30;
        exp_q.push_back({1'b0, 8'h10});
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b0, 8'h12});
        exp_q.push_back({1'b0, 8'h13});
        exp_q.push_back({1'b0, 8'h14});
        push(8'h10);
        push(8'h11);
        push(8'h12);
        push(8'h13);
        push(8'h14);
        chk("t3_level_full", {29'h0, bus.cpu_fifo_level}, 4);
        chk("t3_full_flag", {31'h0, bus.cpu_fifo_full}, 1);
        chk("t3_no_ovf_yet", {31'h0, bus.cpu_ovf}, 0);
        push(8'h55);
        chk("t3_ovf_set", {31'h0, bus.cpu_ovf}, 1);
        chk("t3_level_stays", {29'h0, bus.cpu_fifo_level}, 4);
        @(negedge clk);
        bus.cpu_ovf_clr = 1'b1;
        @(posedge clk); #1;
        bus.cpu_ovf_clr = 1'b0;
        chk("t3_ovf_cleared", {31'h0, bus.cpu_ovf}, 0);
        @(negedge clk);
        bus.cpu_ovf_clr = 1'b1;
        bus.cpu_wr_en   = 1'b1;
        bus.cpu_wr_data = 8'h66;
        @(posedge clk); #1;
        bus.cpu_ovf_clr = 1'b0;
        bus.cpu_wr_en   = 1'b0;
        chk("t3_set_beats_clear", {31'h0, bus.cpu_ovf}, 1);
        chk("t3_level_after_drop", {29'h0, bus.cpu_fifo_level}, 4);
        wait_drain("t3", 400);

        // T4: busy never rises. The lost start must not be retried.
        never_busy = 1'b1;
        base = en_cnt;
        exp_q.push_back({1'b0, 8'h21});
        exp_q.push_back({1'b0, 8'h22});
        push(8'h21);
        push(8'h22);
        wait_drain("t4", 100);
        chk("t4_en_count", en_cnt - base, 2);
        chk("t4_en_gap", en_last - en_prev, 2 + BUSY_WAIT);
        repeat (10) @(posedge clk);
        #1;
        chk("t4_no_duplicate_en", en_cnt - base, 2);
        never_busy = 1'b0;

        // T5: reset while in WAIT_DONE with two bytes queued.
        // cpu_ovf is still set from T3.
        busy_len = 20;
        exp_q.push_back({1'b0, 8'h31});
        push(8'h31);
        push(8'h32);
        push(8'h33);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_busy_before_reset", {31'h0, bus.uart_tx_busy}, 1);
        chk("t5_two_queued", {29'h0, bus.cpu_fifo_level}, 2);
        chk("t5_ovf_before_reset", {31'h0, bus.cpu_ovf}, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t5_rst_level", {29'h0, bus.cpu_fifo_level}, 0);
        chk("t5_rst_en", {31'h0, bus.uart_tx_en}, 0);
        chk("t5_rst_trc_ready", {31'h0, bus.trc_ready}, 0);
        chk("t5_rst_ovf", {31'h0, bus.cpu_ovf}, 0);
        chk("t5_rst_active", {31'h0, bus.tx_active}, 0);
        @(negedge clk);
        rst = 1'b0;
        base = en_cnt;
        repeat (40) @(posedge clk);
        #1;
        chk("t5_no_en_after_reset", en_cnt - base, 0);

        // T6: push and pop in the same cycle at level 2, then stream
        // 10 bytes through the pointer wrap.
        busy_len = 4;
        for (int i = 0; i < 10; i++) exp_q.push_back({1'b0, 8'h40 + 8'(i)});
        push(8'h40);
        @(posedge clk); #1;
        chk("t6_first_en", {31'h0, bus.uart_tx_en}, 1);
        push(8'h41);
        push(8'h42);
        chk("t6_level_two", {29'h0, bus.cpu_fifo_level}, 2);
        repeat (4) @(posedge clk);
        #1;
        chk("t6_level_before_pop", {29'h0, bus.cpu_fifo_level}, 2);
        chk("t6_idle_no_en", {31'h0, bus.uart_tx_en}, 0);
        push(8'h43);
        chk("t6_push_pop_same_cycle", {29'h0, bus.cpu_fifo_level}, 2);
        chk("t6_pop_started", {31'h0, bus.uart_tx_en}, 1);
        for (int i = 4; i < 10; i++) begin
            n = 0;
            while (bus.cpu_fifo_full === 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
            push(8'h40 + 8'(i));
        end
        wait_drain("t6", 400);
        chk("t6_ovf_clear", {31'h0, bus.cpu_ovf}, 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
